// File: rtl/cpu_pkg.sv
// Shared definitions for the mini-RISC datapath.
//   WIDTH      data/bus width; Z and the Booth product are 2*WIDTH wide
//   OP_*       ALU opcodes decoded from IR[3:0]
package cpu_pkg;

    localparam int WIDTH = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b1011;

endpackage

// File: rtl/cpu_booth_mul.sv
// booth_mul: combinational signed WIDTH x WIDTH -> 2*WIDTH multiplier,
// radix-2 Booth recoding with all WIDTH iterations unrolled.
// Ports:
//   a        in   WIDTH    multiplicand (signed)
//   b        in   WIDTH    multiplier (signed)
//   product  out  2*WIDTH  signed product
module booth_mul
    import cpu_pkg::*;
#(
    parameter int DW = WIDTH
) (
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] product
);

    // Accumulator layout: {upper partial product (DW+1), multiplier (DW), Booth guard bit}.
    // The upper part carries one extra bit so that subtracting the most negative
    // multiplicand cannot overflow before the arithmetic shift.
    logic [2*DW+1:0] acc;
    logic [DW:0]     upper;
    logic [DW:0]     a_ext;

    always_comb begin
        a_ext = {a[DW-1], a};
        upper = '0;
        acc   = {{(DW+1){1'b0}}, b, 1'b0};
        for (int i = 0; i < DW; i++) begin
            upper = acc[2*DW+1:DW+1];
            case (acc[1:0])
                2'b01:   upper = upper + a_ext;
                2'b10:   upper = upper - a_ext;
                default: upper = upper;
            endcase
            acc = {upper[DW], upper, acc[DW:1]};
        end
        product = acc[2*DW:1];
    end

endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: single-bus datapath for the mini-RISC lab processor.
// Registers R1/R4/R5, PC, IR, MDR, Y, 64-bit Z, HI/LO and a Booth ALU share
// one combinational bus; an external sequencer drives every strobe.
// Ports:
//   clock                 in   1      rising-edge clock
//   clear                 in   1      asynchronous active-high reset
//   Mdatain               in   WIDTH  memory read data
//   Read                  in   1      MDR source select: 1 = Mdatain, 0 = bus
//   MDRin / MDRout        in   1      MDR load / bus drive
//   PCout                 in   1      PC bus drive
//   IRin, Yin             in   1      IR / Y load from bus
//   R1in, R4in, R5in      in   1      register loads from bus
//   R4out, R5out          in   1      register bus drives
//   AND                   in   1      ALU execute: Z <= op(Y, bus), op = IR[3:0]
//   Zlowout, Zhighout     in   1      Z halves drive bus
//   LOin, HIin            in   1      LO / HI load from bus
//   BusMuxOut             out  WIDTH  current bus value
//   IR, HI, LO            out  WIDTH  register contents
module cpu_datapath #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] PC_RST = '0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic             Read,
    input  logic             MDRin,
    input  logic             MDRout,
    input  logic             PCout,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             R1in,
    input  logic             R4in,
    input  logic             R5in,
    input  logic             R4out,
    input  logic             R5out,
    input  logic             AND,
    input  logic             Zlowout,
    input  logic             Zhighout,
    input  logic             LOin,
    input  logic             HIin,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] IR,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    import cpu_pkg::*;

    logic [WIDTH-1:0]   r1, r4, r5, pc, mdr, y;
    logic [2*WIDTH-1:0] z;
    logic [WIDTH-1:0]   bus;
    logic [WIDTH-1:0]   mdr_d;
    logic [2*WIDTH-1:0] z_next;
    logic [2*WIDTH-1:0] product;

    // R1 has no bus driver in this slice; it is kept for the sequencer's sake.
    logic unused_r1;
    assign unused_r1 = ^r1;

    always_comb begin
        bus = '0;
        if (Zhighout)     bus = z[2*WIDTH-1:WIDTH];
        else if (Zlowout) bus = z[WIDTH-1:0];
        else if (MDRout)  bus = mdr;
        else if (PCout)   bus = pc;
        else if (R4out)   bus = r4;
        else if (R5out)   bus = r5;
    end

    assign BusMuxOut = bus;
    assign mdr_d     = Read ? Mdatain : bus;

    booth_mul #(.DW(WIDTH)) u_booth (
        .a       (y),
        .b       (bus),
        .product (product)
    );

    // Non-multiply results are zero-extended; adder carry is discarded.
    always_comb begin
        z_next = {{WIDTH{1'b0}}, y & bus};
        case (IR[3:0])
            OP_OR:   z_next = {{WIDTH{1'b0}}, y | bus};
            OP_ADD:  z_next = {{WIDTH{1'b0}}, y + bus};
            OP_SUB:  z_next = {{WIDTH{1'b0}}, y - bus};
            OP_MUL:  z_next = product;
            default: z_next = {{WIDTH{1'b0}}, y & bus};
        endcase
    end

    // Generic enabled-register process; PC has no load path and only resets.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r1  <= '0;
            r4  <= '0;
            r5  <= '0;
            pc  <= PC_RST;
            IR  <= '0;
            mdr <= '0;
            y   <= '0;
            z   <= '0;
            HI  <= '0;
            LO  <= '0;
        end else begin
            if (R1in)  r1  <= bus;
            if (R4in)  r4  <= bus;
            if (R5in)  r5  <= bus;
            if (IRin)  IR  <= bus;
            if (MDRin) mdr <= mdr_d;
            if (Yin)   y   <= bus;
            if (AND)   z   <= z_next;
            if (HIin)  HI  <= bus;
            if (LOin)  LO  <= bus;
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
module tb_cpu_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] Mdatain;
    logic        Read, MDRin, MDRout, PCout, IRin, Yin;
    logic        R1in, R4in, R5in, R4out, R5out;
    logic        AND, Zlowout, Zhighout, LOin, HIin;
    logic [31:0] BusMuxOut, IR, HI, LO;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_datapath #(.WIDTH(32), .PC_RST(32'h0)) dut (
        .clock     (clock),
        .clear     (clear),
        .Mdatain   (Mdatain),
        .Read      (Read),
        .MDRin     (MDRin),
        .MDRout    (MDRout),
        .PCout     (PCout),
        .IRin      (IRin),
        .Yin       (Yin),
        .R1in      (R1in),
        .R4in      (R4in),
        .R5in      (R5in),
        .R4out     (R4out),
        .R5out     (R5out),
        .AND       (AND),
        .Zlowout   (Zlowout),
        .Zhighout  (Zhighout),
        .LOin      (LOin),
        .HIin      (HIin),
        .BusMuxOut (BusMuxOut),
        .IR        (IR),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic all_off();
        Read = 0; MDRin = 0; MDRout = 0; PCout = 0; IRin = 0; Yin = 0;
        R1in = 0; R4in = 0; R5in = 0; R4out = 0; R5out = 0;
        AND = 0; Zlowout = 0; Zhighout = 0; LOin = 0; HIin = 0;
    endtask

    // Strobes set before the call are sampled at the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
        all_off();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1;
        tick();
    endtask

    task automatic load_r4(input logic [31:0] v);
        load_mdr(v);
        MDRout = 1; R4in = 1;
        tick();
    endtask

    task automatic load_r5(input logic [31:0] v);
        load_mdr(v);
        MDRout = 1; R5in = 1;
        tick();
    endtask

    task automatic load_ir(input logic [31:0] v);
        load_mdr(v);
        MDRout = 1; IRin = 1;
        tick();
    endtask

    // IR = op, Y <= R4, Z <= op(Y, R5), LO <= Zlow, HI <= Zhigh.
    task automatic run_op(input string tag, input logic [31:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        load_ir(op);
        load_r4(a);
        load_r5(b);
        R4out = 1; Yin = 1;
        tick();
        R5out = 1; AND = 1;
        tick();
        Zlowout = 1; LOin = 1;
        tick();
        Zhighout = 1; HIin = 1;
        tick();
        check({tag, "_lo"}, LO, exp_lo);
        check({tag, "_hi"}, HI, exp_hi);
    endtask

    initial begin
        all_off();
        Mdatain = 32'h0;
        clear = 1;
        #12;
        check("rst_ir", IR, 32'h0);
        check("rst_hi", HI, 32'h0);
        check("rst_lo", LO, 32'h0);
        check("rst_bus_idle", BusMuxOut, 32'h0);
        PCout = 1; #1;
        check("rst_pc", BusMuxOut, 32'h0);
        PCout = 0;
        clear = 0;

        // Load path through MDR
        load_mdr(32'h12);
        MDRout = 1; #1;
        check("mdr_bus", BusMuxOut, 32'h12);
        R4in = 1;
        tick();
        R4out = 1; #1;
        check("r4_load", BusMuxOut, 32'h12);
        R4out = 0;
        load_r5(32'h04);
        R5out = 1; #1;
        check("r5_load", BusMuxOut, 32'h04);
        R5out = 0;

        // Same-cycle write and read of MDR: bus shows old value
        Mdatain = 32'h99; Read = 1; MDRin = 1; MDRout = 1; #1;
        check("mdr_old_on_bus", BusMuxOut, 32'h04);
        tick();
        MDRout = 1; #1;
        check("mdr_new_after", BusMuxOut, 32'h99);
        MDRout = 0;

        // ALU operations
        run_op("and_zero", 32'h0, 32'h12, 32'h04, 32'h0, 32'h0);
        run_op("and_mask", 32'h0, 32'hF0F0, 32'hFF00, 32'h0, 32'hF000);
        run_op("or", 32'h1, 32'hF0F0, 32'hFF00, 32'h0, 32'hFFF0);
        run_op("add_wrap", 32'h2, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
        run_op("sub_neg", 32'h3, 32'h5, 32'h7, 32'h0, 32'hFFFFFFFE);
        run_op("op5_is_and", 32'h5, 32'hF0F0, 32'hFF00, 32'h0, 32'hF000);
        run_op("mul_pos", 32'hB, 32'h12, 32'h04, 32'h0, 32'h48);
        run_op("mul_min", 32'hB, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
        run_op("mul_max", 32'hB, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h1);
        run_op("mul_m1", 32'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
        run_op("mul_neg", 32'hB, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        check("ir_mul", IR, 32'hB);

        // Bus priority: Z = {FFFFFFFF, FFFFFFEB}, R4 = FFFFFFFD, R5 = 7, PC = 0
        load_mdr(32'hA5A5A5A5);
        Zhighout = 1; Zlowout = 1; MDRout = 1; #1;
        check("prio_zhi", BusMuxOut, 32'hFFFFFFFF);
        Zhighout = 0; R4out = 1; #1;
        check("prio_zlo", BusMuxOut, 32'hFFFFFFEB);
        Zlowout = 0; PCout = 1; #1;
        check("prio_mdr", BusMuxOut, 32'hA5A5A5A5);
        MDRout = 0; #1;
        check("prio_pc", BusMuxOut, 32'h0);
        PCout = 0; R5out = 1; #1;
        check("prio_r4", BusMuxOut, 32'hFFFFFFFD);
        R4out = 0;

        // Read=0: MDR takes the bus (R5 = 7), not Mdatain
        Mdatain = 32'h55; Read = 0; MDRin = 1; R5out = 1;
        tick();
        MDRout = 1; #1;
        check("mdr_from_bus", BusMuxOut, 32'h7);
        MDRout = 0;

        // Mid-cycle asynchronous reset
        @(posedge clock);
        #3;
        clear = 1;
        #1;
        check("arst_ir", IR, 32'h0);
        check("arst_hi", HI, 32'h0);
        check("arst_lo", LO, 32'h0);
        Zlowout = 1; #1;
        check("arst_z", BusMuxOut, 32'h0);
        Zlowout = 0; R4out = 1; #1;
        check("arst_r4", BusMuxOut, 32'h0);
        R4out = 0;
        Mdatain = 32'h77; Read = 1; MDRin = 1;
        tick();
        MDRout = 1; #1;
        check("arst_overrides_load", BusMuxOut, 32'h0);
        MDRout = 0;
        #2;
        clear = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
